// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter that time-shares one pipelined WIDTHxWIDTH multiplier
// among NREQ valid/ready requesters, returning id-tagged products in accept order.
module mul_share_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned IDW     = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [WIDTH-1:0]        rsp_data,
  output logic                    rsp_ovf
);

  localparam int unsigned LAST = MUL_LAT - 1;
  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned SW   = IDW + 1;

  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   winner_c;
  logic             found_c;
  logic             advance_c;
  logic             accept_c;
  logic [WIDTH-1:0] a_c;
  logic [WIDTH-1:0] b_c;
  logic [PW-1:0]    prod_c;

  logic [MUL_LAT-1:0] stg_valid;
  logic [MUL_LAT-1:0] stg_ovf;
  logic [IDW-1:0]     stg_id   [MUL_LAT];
  logic [WIDTH-1:0]   stg_data [MUL_LAT];

  // Whole pipeline, output register included, moves only when the output can drain.
  assign advance_c = !stg_valid[LAST] || rsp_ready;

  // Circular scan from ptr: first valid requester wins.
  always_comb begin : rr_pick
    logic [SW-1:0]  sum;
    logic [IDW-1:0] idx;
    found_c  = 1'b0;
    winner_c = '0;
    sum      = '0;
    idx      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + SW'(k);
      if (sum >= SW'(NREQ)) begin
        sum = sum - SW'(NREQ);
      end
      idx = IDW'(sum);
      if (!found_c && req_valid[idx]) begin
        found_c  = 1'b1;
        winner_c = idx;
      end
    end
  end

  assign accept_c = advance_c && found_c && !rst;

  always_comb begin : grant_vec
    req_ready = '0;
    if (accept_c) begin
      req_ready[winner_c] = 1'b1;
    end
  end

  assign a_c    = req_a[winner_c*WIDTH +: WIDTH];
  assign b_c    = req_b[winner_c*WIDTH +: WIDTH];
  assign prod_c = PW'(a_c) * PW'(b_c);

  // Priority rotates to the requester after the one just accepted.
  always_ff @(posedge clk or posedge rst) begin : ptr_reg
    if (rst) begin
      ptr <= '0;
    end else if (accept_c) begin
      ptr <= (winner_c == IDW'(NREQ - 1)) ? '0 : winner_c + IDW'(1);
    end
  end

  // Stage 0 captures the tagged product; later stages delay it, bubbles included.
  always_ff @(posedge clk or posedge rst) begin : pipe
    if (rst) begin
      stg_valid <= '0;
      stg_ovf   <= '0;
      for (int unsigned i = 0; i < MUL_LAT; i++) begin
        stg_id[i]   <= '0;
        stg_data[i] <= '0;
      end
    end else if (advance_c) begin
      stg_valid[0] <= accept_c;
      if (accept_c) begin
        stg_id[0]   <= winner_c;
        stg_data[0] <= prod_c[WIDTH-1:0];
        stg_ovf[0]  <= |prod_c[PW-1:WIDTH];
      end
      for (int unsigned i = 1; i < MUL_LAT; i++) begin
        stg_valid[i] <= stg_valid[i-1];
        stg_id[i]    <= stg_id[i-1];
        stg_data[i]  <= stg_data[i-1];
        stg_ovf[i]   <= stg_ovf[i-1];
      end
    end
  end

  assign rsp_valid = stg_valid[LAST];
  assign rsp_id    = stg_id[LAST];
  assign rsp_data  = stg_data[LAST];
  assign rsp_ovf   = stg_ovf[LAST];

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter: directed scenarios plus a random soak.
module tb_mul_share_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned MUL_LAT = 2;
  localparam int unsigned IDW     = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_ovf;

  mul_share_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .MUL_LAT(MUL_LAT), .IDW(IDW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ovf(rsp_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned id;
    int unsigned data;
    int unsigned ovf;
  } exp_t;

  exp_t q[$];
  int   grant_log[$];
  int   rsp_log[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_ptr    = 0;

  logic           prev_hold = 1'b0;
  logic [IDW-1:0] prev_id;
  logic [WIDTH-1:0] prev_data;
  logic           prev_ovf;

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int lane, input int a, input int b);
    req_a[lane*WIDTH +: WIDTH] = WIDTH'(a);
    req_b[lane*WIDTH +: WIDTH] = WIDTH'(b);
  endtask

  // Monitor: independent round-robin model for grants, queue for responses.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_ptr     = 0;
      prev_hold = 1'b0;
      chk("ready_in_reset", req_ready, 0);
    end else begin
      automatic logic adv = !rsp_valid || rsp_ready;
      automatic int w = -1;
      automatic int unsigned exp_rdy = 0;
      for (int k = 0; k < NREQ; k++) begin
        automatic int idx = (m_ptr + k) % NREQ;
        if (w < 0 && req_valid[idx]) w = idx;
      end
      if (adv && w >= 0) exp_rdy = 1 << w;
      chk("grant", req_ready, exp_rdy);
      if (prev_hold) begin
        chk("hold_stable", {rsp_valid, rsp_id, rsp_data, rsp_ovf},
            {1'b1, prev_id, prev_data, prev_ovf});
      end
      if (rsp_valid && rsp_ready) begin
        chk("rsp_expected", q.size() > 0, 1);
        rsp_log.push_back(int'(rsp_id));
        if (q.size() > 0) begin
          automatic exp_t e = q.pop_front();
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_ovf", rsp_ovf, e.ovf);
        end
      end
      if (adv && w >= 0) begin
        automatic int unsigned a = req_a[w*WIDTH +: WIDTH];
        automatic int unsigned b = req_b[w*WIDTH +: WIDTH];
        automatic int unsigned p = a * b;
        automatic exp_t e;
        e.id   = w;
        e.data = p % 256;
        e.ovf  = (p >= 256) ? 1 : 0;
        q.push_back(e);
        grant_log.push_back(w);
        m_ptr = (w + 1) % NREQ;
      end
      prev_hold = rsp_valid && !rsp_ready;
      prev_id   = rsp_id;
      prev_data = rsp_data;
      prev_ovf  = rsp_ovf;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [IDW-1:0]   snap_id;
    logic [WIDTH-1:0] snap_data;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    repeat (3) step();
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_ovf", rsp_ovf, 0);
    rst = 1'b0;

    // Single lane: 12*11 = 132, then 16*16 = 256 -> data 0, overflow
    set_op(2, 12, 11); req_valid = 4'b0100;
    step(); req_valid = '0;
    chk("lat_not_early", rsp_valid, 0);
    step();
    chk("lat_valid", rsp_valid, 1);
    chk("lat_id", rsp_id, 2);
    chk("lat_data", rsp_data, 132);
    chk("lat_ovf", rsp_ovf, 0);
    set_op(2, 16, 16); req_valid = 4'b0100;
    step(); req_valid = '0;
    step();
    chk("ovf_valid", rsp_valid, 1);
    chk("ovf_data", rsp_data, 0);
    chk("ovf_flag", rsp_ovf, 1);
    step();

    // Reset mid-flight, then fairness from requester 0
    set_op(0, 3, 5); set_op(1, 200, 2); set_op(2, 7, 9); set_op(3, 255, 255);
    req_valid = 4'b1111;
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk("async_reset_rsp_valid", rsp_valid, 0);
    repeat (2) step();
    rst = 1'b0;
    grant_log.delete(); rsp_log.delete();
    chk("post_reset_quiet", rsp_valid, 0);
    repeat (8) step();
    req_valid = '0;
    repeat (4) step();
    chk("rr_grant_count", grant_log.size(), 8);
    chk("rr_rsp_count", rsp_log.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rr_grant%0d", i), (grant_log.size() > i) ? grant_log[i] : -1, i % 4);
      chk($sformatf("rr_rsp%0d", i), (rsp_log.size() > i) ? rsp_log[i] : -1, i % 4);
    end

    // Backpressure: 3 stalled cycles with requesters valid
    req_valid = 4'b1111;
    repeat (2) step();
    rsp_ready = 1'b0;
    snap_id = rsp_id; snap_data = rsp_data;
    chk("bp_full", rsp_valid, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_ready_zero", req_ready, 0);
      chk("bp_id_stable", rsp_id, snap_id);
      chk("bp_data_stable", rsp_data, snap_data);
    end
    rsp_ready = 1'b1; req_valid = '0;
    repeat (4) step();
    chk("bp_drained", q.size(), 0);

    // Sparse plus wrap: park ptr at 3, then only 1 and 3 valid
    rst = 1'b1; step(); rst = 1'b0;
    grant_log.delete();
    req_valid = 4'b0100; step();
    req_valid = 4'b1010;
    repeat (3) step();
    req_valid = 4'b0001; rsp_ready = 1'b0;
    repeat (2) step();
    req_valid = '0; step();
    rsp_ready = 1'b1;
    repeat (4) step();
    chk("wrap_count", grant_log.size(), 4);
    chk("wrap_g0", (grant_log.size() > 0) ? grant_log[0] : -1, 2);
    chk("wrap_g1", (grant_log.size() > 1) ? grant_log[1] : -1, 3);
    chk("wrap_g2", (grant_log.size() > 2) ? grant_log[2] : -1, 1);
    chk("wrap_g3", (grant_log.size() > 3) ? grant_log[3] : -1, 3);
    chk("withdrawn_drained", q.size(), 0);

    // Random soak against the scoreboard
    for (int c = 0; c < 10000; c++) begin
      req_valid = NREQ'($urandom);
      req_a     = (NREQ*WIDTH)'($urandom);
      req_b     = (NREQ*WIDTH)'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = '0; rsp_ready = 1'b1;
    for (int c = 0; c < 50 && (q.size() > 0 || rsp_valid); c++) step();
    chk("soak_drained", q.size(), 0);
    chk("soak_idle", rsp_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Round-robin arbiter and sequencer that shares one pipelined WIDTH×WIDTH multiplier among NREQ requesters. Each requester presents operand pairs over a valid/ready handshake. The block grants one requester per cycle, tags each operation with its requester ID, and returns the truncated product on a single shared response port with backpressure. It sits between the per-lane control logic and the multiply datapath, so several lanes can time-share one multiplier instead of each owning a dedicated register-feedback multiplier.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, operand and result width
- MUL_LAT, 2, multiplier pipeline depth in cycles from accept to response (1..4)
- IDW, $clog2(NREQ), width of the requester ID
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  bit i: requester i offers an operation
- req_a  in  NREQ*WIDTH  operand A, requester i in bits [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand B, same packing
- req_ready  out  NREQ  bit i: operation of requester i is accepted this cycle (one-hot or zero)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  IDW  requester that issued the operation
- rsp_data  out  WIDTH  (a*b) mod 2^WIDTH
- rsp_ovf  out  1  high WIDTH bits of the full 2*WIDTH product are non-zero

## Operation
- advance = !rsp_valid || rsp_ready. The whole pipeline, including the output stage, moves only when advance=1. Otherwise every stage holds.
- Grant is combinational. Starting at the priority pointer ptr, the first i in circular order with req_valid[i]=1 wins. req_ready[i] = advance && winner==i && !rst.
- Accept = req_valid[i] && req_ready[i]. On accept, {id, a, b} enter stage 0 and ptr <= (i+1) mod NREQ. If nothing is accepted, ptr holds.
- Stages 0..MUL_LAT-1 each hold a valid bit, id and partial or full product. The product is computed at full 2*WIDTH width. rsp_data is the low WIDTH bits. rsp_ovf is the OR of the high WIDTH bits.
- Last stage = output register: rsp_valid, rsp_id, rsp_data and rsp_ovf come straight from flops.
- Bubbles propagate as valid=0. Bubbles are not squeezed out; throughput is 1 op/cycle when rsp_ready=1.
- Operands are sampled only on accept. Changes on a requester that is not granted have no effect.
- A requester that drops req_valid before being accepted loses nothing. It is simply not granted.
- A requester is never starved: after requester i raises req_valid, it is accepted within NREQ advancing cycles.
- Responses leave in accept order. No reordering occurs.

## Timing
- Reset (asynchronous assert, synchronous-clean deassert): rsp_valid=0, rsp_id=0, rsp_data=0, rsp_ovf=0, ptr=0, all stage valid bits cleared. In-flight operations are discarded and produce no response. req_ready=0 while rst=1.
- First edge after rst falls: requester 0 has top priority.
- Latency: an operation accepted at edge T shows rsp_valid=1 after edge T+MUL_LAT-1 (visible in cycle T+MUL_LAT), provided advance stayed 1.
- Each cycle with advance=0 adds exactly one cycle of latency to every in-flight operation.
- Response handshake: rsp_valid && rsp_ready completes the transfer. While rsp_valid=1 and rsp_ready=0, rsp_id, rsp_data and rsp_ovf are stable and req_ready=0.
- Simultaneous events: a response consumed and a new request accepted in the same cycle is legal and required for full throughput.
- Full pipeline + stall: at most MUL_LAT operations are in flight. No accept occurs while stalled.
- ptr wraps: NREQ-1 → 0.
- A single requester continuously valid with the others idle is accepted every advancing cycle.

## Test plan
- Reset mid-flight: accept 3 ops, assert rst on the next cycle. Required: rsp_valid=0 immediately (asynchronous), no response after release, and the first grant after release goes to requester 0 when all requesters are valid.
- Single lane, MUL_LAT=2, rsp_ready=1: requester 2 sends a=12, b=11, accepted at T. Required: rsp_valid in cycle T+2 with rsp_id=2, rsp_data=132, rsp_ovf=0. Then send a=16, b=16. Required: rsp_data=0, rsp_ovf=1.
- Round-robin fairness: all 4 requesters valid continuously for 8 cycles. Required: grants go 0,1,2,3,0,1,2,3, and responses carry IDs in the same order, one per cycle.
- Backpressure: hold rsp_ready=0 for 3 cycles while requesters are valid. Required: req_ready stays all-zero after the pipeline fills, rsp_* is stable for all 3 cycles, and releasing rsp_ready delivers the held ops in order with nothing lost or duplicated.
- Sparse plus wrap: ptr=3 and only requesters 1 and 3 valid. Required: 3 is granted, then 1, then 3. A request withdrawn before its grant produces no response.
- Random soak: random valid, operands and rsp_ready for 10k cycles against a reference queue model. Required: every accepted op returns exactly once, in order, with correct id, mod-256 product and overflow flag.
